// File: rtl/ht_traffic_gen.sv
// Hash table command source and result checker for on-chip bring-up and soak runs.
// Issues an insert/search/delete sweep over N keys and scores every echoed result.
module ht_traffic_gen #(
  parameter int unsigned          KEY_WIDTH   = 32,
  parameter int unsigned          VALUE_WIDTH = 16,
  parameter int unsigned          CNT_WIDTH   = 16,
  parameter logic [VALUE_WIDTH-1:0] VALUE_XOR = 16'hA5C3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   num_keys_i,
  input  logic [KEY_WIDTH-1:0]   key_base_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic [KEY_WIDTH-1:0]   cmd_key_o,
  output logic [VALUE_WIDTH-1:0] cmd_value_o,
  output logic [1:0]             cmd_opcode_o,
  input  logic                   res_valid_i,
  output logic                   res_ready_o,
  input  logic [KEY_WIDTH-1:0]   res_key_i,
  input  logic [1:0]             res_opcode_i,
  input  logic [2:0]             res_rescode_i,
  input  logic [VALUE_WIDTH-1:0] res_found_value_i,
  output logic [CNT_WIDTH-1:0]   ok_cnt_o,
  output logic [CNT_WIDTH-1:0]   err_cnt_o,
  output logic [KEY_WIDTH-1:0]   first_err_key_o,
  output logic                   first_err_valid_o
);

  localparam logic [1:0] OP_SEARCH         = 2'd0;
  localparam logic [1:0] OP_INSERT         = 2'd1;
  localparam logic [1:0] OP_DELETE         = 2'd2;
  localparam logic [2:0] RC_SEARCH_FOUND   = 3'd0;
  localparam logic [2:0] RC_INSERT_SUCCESS = 3'd2;
  localparam logic [2:0] RC_DELETE_SUCCESS = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {PH_INSERT, PH_SEARCH, PH_DELETE} phase_t;

  state_t                 state_q, state_d;
  phase_t                 phase_q, phase_d;
  logic [CNT_WIDTH-1:0]   n_q, n_d, idx_q, idx_d, out_q, out_d, ok_d, err_d;
  logic [KEY_WIDTH-1:0]   base_q, base_d, ferr_key_d, key_d;
  logic                   ferr_valid_d, busy_d, done_d, valid_d;
  logic [VALUE_WIDTH-1:0] value_d;
  logic [1:0]             opcode_d;
  logic                   start_ok, hs, res_pass, op_known;
  logic [2:0]             exp_rc;

  assign res_ready_o = 1'b1;
  assign start_ok    = start_i && (state_q == S_IDLE || state_q == S_DONE);
  assign hs          = (state_q == S_ISSUE) && cmd_ready_i;

  // Result check: echoed opcode selects the expected rescode; unsolicited results always fail
  always_comb begin
    exp_rc   = RC_SEARCH_FOUND;
    op_known = 1'b1;
    case (res_opcode_i)
      OP_INSERT: exp_rc = RC_INSERT_SUCCESS;
      OP_SEARCH: exp_rc = RC_SEARCH_FOUND;
      OP_DELETE: exp_rc = RC_DELETE_SUCCESS;
      default:   op_known = 1'b0;
    endcase
    res_pass = (out_q != '0) && op_known && (res_rescode_i == exp_rc) &&
               ((res_opcode_i != OP_SEARCH) ||
                (res_found_value_i == (res_key_i[VALUE_WIDTH-1:0] ^ VALUE_XOR)));
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= S_IDLE;
      phase_q           <= PH_INSERT;
      n_q               <= '0;
      base_q            <= '0;
      idx_q             <= '0;
      out_q             <= '0;
      ok_cnt_o          <= '0;
      err_cnt_o         <= '0;
      first_err_key_o   <= '0;
      first_err_valid_o <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      cmd_valid_o       <= 1'b0;
      cmd_key_o         <= '0;
      cmd_value_o       <= '0;
      cmd_opcode_o      <= '0;
    end else begin
      state_q           <= state_d;
      phase_q           <= phase_d;
      n_q               <= n_d;
      base_q            <= base_d;
      idx_q             <= idx_d;
      out_q             <= out_d;
      ok_cnt_o          <= ok_d;
      err_cnt_o         <= err_d;
      first_err_key_o   <= ferr_key_d;
      first_err_valid_o <= ferr_valid_d;
      busy_o            <= busy_d;
      done_o            <= done_d;
      cmd_valid_o       <= valid_d;
      cmd_key_o         <= key_d;
      cmd_value_o       <= value_d;
      cmd_opcode_o      <= opcode_d;
    end
  end

  // Next state, sweep position, outstanding tracking and scoring
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    n_d          = n_q;
    base_d       = base_q;
    idx_d        = idx_q;
    out_d        = out_q + CNT_WIDTH'(hs) - CNT_WIDTH'(res_valid_i && (out_q != '0));
    ok_d         = ok_cnt_o;
    err_d        = err_cnt_o;
    ferr_key_d   = first_err_key_o;
    ferr_valid_d = first_err_valid_o;

    if (res_valid_i) begin
      if (res_pass) begin
        if (ok_cnt_o != '1) ok_d = ok_cnt_o + CNT_WIDTH'(1);
      end else begin
        if (err_cnt_o != '1) err_d = err_cnt_o + CNT_WIDTH'(1);
        if (!first_err_valid_o) begin
          ferr_key_d   = res_key_i;
          ferr_valid_d = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          n_d          = num_keys_i;
          base_d       = key_base_i;
          idx_d        = '0;
          out_d        = '0;
          ok_d         = '0;
          err_d        = '0;
          ferr_key_d   = '0;
          ferr_valid_d = 1'b0;
          phase_d      = PH_INSERT;
          state_d      = (num_keys_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          idx_d = idx_q + CNT_WIDTH'(1);
          if (idx_q == n_q - CNT_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_q == '0) begin
          if (phase_q == PH_DELETE) begin
            state_d = S_DONE;
          end else begin
            phase_d = (phase_q == PH_INSERT) ? PH_SEARCH : PH_DELETE;
            idx_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from next-state values so they align with the state
  always_comb begin
    busy_d   = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE) && ((state_q != S_DONE) || start_ok);
    valid_d  = (state_d == S_ISSUE);
    key_d    = base_d + KEY_WIDTH'(idx_d);
    value_d  = '0;
    opcode_d = OP_INSERT;
    case (phase_d)
      PH_INSERT: begin
        opcode_d = OP_INSERT;
        value_d  = key_d[VALUE_WIDTH-1:0] ^ VALUE_XOR;
      end
      PH_SEARCH: opcode_d = OP_SEARCH;
      default:   opcode_d = OP_DELETE;
    endcase
  end

endmodule

// File: tb/tb_ht_traffic_gen.sv
// Directed bench for ht_traffic_gen: a cycle-level responder model plus per-scenario checks.
module tb_ht_traffic_gen;

  localparam logic [1:0]  OP_SEARCH = 2'd0;
  localparam logic [1:0]  OP_INSERT = 2'd1;
  localparam logic [1:0]  OP_DELETE = 2'd2;
  localparam logic [2:0]  RC_FOUND  = 3'd0;
  localparam logic [2:0]  RC_INS    = 3'd2;
  localparam logic [2:0]  RC_DEL    = 3'd5;
  localparam logic [15:0] VXOR      = 16'hA5C3;

  typedef struct packed {
    logic [31:0] key;
    logic [1:0]  op;
    logic [15:0] value;
  } cmd_t;

  logic        clk, rst_i, start_i, cmd_ready_i, res_valid_i;
  logic [15:0] num_keys_i;
  logic [31:0] key_base_i;
  logic        busy_o, done_o, cmd_valid_o, res_ready_o, first_err_valid_o;
  logic [31:0] cmd_key_o, res_key_i, first_err_key_o;
  logic [15:0] cmd_value_o, res_found_value_i, ok_cnt_o, err_cnt_o;
  logic [1:0]  cmd_opcode_o, res_opcode_i;
  logic [2:0]  res_rescode_i;

  int   checks = 0;
  int   errors = 0;
  cmd_t cmd_log[$];
  cmd_t pend[$];
  int   done_pulses, stall_viol, order_viol, ins_res_sent;
  logic [7:0] lfsr = 8'hA5;

  ht_traffic_gen dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_keys_i(num_keys_i),
    .key_base_i(key_base_i), .busy_o(busy_o), .done_o(done_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_key_o(cmd_key_o),
    .cmd_value_o(cmd_value_o), .cmd_opcode_o(cmd_opcode_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_key_i(res_key_i),
    .res_opcode_i(res_opcode_i), .res_rescode_i(res_rescode_i),
    .res_found_value_i(res_found_value_i), .ok_cnt_o(ok_cnt_o), .err_cnt_o(err_cnt_o),
    .first_err_key_o(first_err_key_o), .first_err_valid_o(first_err_valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // All tasks enter and leave 1 time unit after a rising edge
  task automatic do_start(input logic [15:0] n, input logic [31:0] base);
    start_i = 1'b1; num_keys_i = n; key_base_i = base;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Responder: logs handshakes, returns results in order or reversed per phase
  task automatic run_resp(input int n, input bit rand_ready, input bit reverse,
                          input bit corrupt, input int stop_hs, output bit timed_out);
    cmd_t r, c, pk;
    bit   releasing, prev_stall, rdy;
    cmd_log.delete(); pend.delete();
    done_pulses = 0; stall_viol = 0; order_viol = 0; ins_res_sent = 0;
    releasing = 0; prev_stall = 0; timed_out = 1; pk = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done_o) done_pulses++;
      if (done_o && stop_hs == 0) begin timed_out = 0; break; end
      if (prev_stall && (cmd_valid_o !== 1'b1 || cmd_key_o !== pk.key ||
                         cmd_opcode_o !== pk.op || cmd_value_o !== pk.value))
        stall_viol++;
      res_valid_i = 1'b0;
      if (reverse && pend.size() == n) releasing = 1;
      if (pend.size() > 0 && (!reverse || releasing)) begin
        r = reverse ? pend.pop_back() : pend.pop_front();
        res_valid_i   = 1'b1;
        res_key_i     = r.key;
        res_opcode_i  = r.op;
        res_rescode_i = (r.op == OP_INSERT) ? RC_INS : (r.op == OP_SEARCH) ? RC_FOUND : RC_DEL;
        res_found_value_i = (r.op == OP_SEARCH) ? (r.key[15:0] ^ VXOR) : 16'h0;
        if (corrupt && r.op == OP_SEARCH && r.key == 32'h102) res_found_value_i = 16'h0;
        if (r.op == OP_INSERT) ins_res_sent++;
        if (pend.size() == 0) releasing = 0;
      end
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      rdy = rand_ready ? lfsr[0] : 1'b1;
      cmd_ready_i = rdy;
      c = '{key: cmd_key_o, op: cmd_opcode_o, value: cmd_value_o};
      if (cmd_valid_o && rdy) begin
        cmd_log.push_back(c);
        pend.push_back(c);
        if (c.op == OP_SEARCH && ins_res_sent != n) order_viol++;
      end
      prev_stall = cmd_valid_o && !rdy;
      pk = c;
      if (stop_hs != 0 && cmd_log.size() == stop_hs) begin timed_out = 0; break; end
      @(posedge clk); #1;
    end
    if (stop_hs == 0) begin
      res_valid_i = 1'b0; cmd_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (done_o) done_pulses++;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 0; cmd_ready_i = 1; res_valid_i = 0;
    num_keys_i = '0; key_base_i = '0; res_key_i = '0; res_opcode_i = '0;
    res_rescode_i = '0; res_found_value_i = '0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({busy_o, done_o, cmd_valid_o, first_err_valid_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy_o, done_o, cmd_valid_o, first_err_valid_o});
    end
    checks++;
    if (res_ready_o !== 1'b1) begin errors++; $display("FAIL reset_res_ready: got %b expected 1", res_ready_o); end
    checks++;
    if ({ok_cnt_o, err_cnt_o, first_err_key_o} !== 64'h0) begin
      errors++; $display("FAIL reset_counters: ok %h err %h fkey %h expected all 0", ok_cnt_o, err_cnt_o, first_err_key_o);
    end
    checks++;
    if ({cmd_key_o, cmd_value_o, cmd_opcode_o} !== 50'h0) begin
      errors++; $display("FAIL reset_cmd: key %h value %h op %h expected 0", cmd_key_o, cmd_value_o, cmd_opcode_o);
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_ideal();
    bit to;
    logic [31:0] ek;
    logic [1:0]  eo;
    logic [15:0] ev;
    do_start(16'd4, 32'h100);
    checks++;
    if ({cmd_valid_o, busy_o} !== 2'b11) begin
      errors++; $display("FAIL first_valid: valid,busy got %b expected 11", {cmd_valid_o, busy_o});
    end
    run_resp(4, 0, 0, 0, 0, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL ideal_timeout: done_o not seen"); end
    checks++;
    if (cmd_log.size() !== 12) begin errors++; $display("FAIL ideal_hs_count: got %0d expected 12", cmd_log.size()); end
    for (int i = 0; i < 12 && i < cmd_log.size(); i++) begin
      ek = 32'h100 + 32'(i % 4);
      eo = (i < 4) ? OP_INSERT : (i < 8) ? OP_SEARCH : OP_DELETE;
      ev = (i < 4) ? (ek[15:0] ^ VXOR) : 16'h0;
      checks++;
      if (cmd_log[i] !== '{key: ek, op: eo, value: ev}) begin
        errors++; $display("FAIL ideal_cmd%0d: got key %h op %0d val %h expected key %h op %0d val %h",
                           i, cmd_log[i].key, cmd_log[i].op, cmd_log[i].value, ek, eo, ev);
      end
    end
    checks++;
    if ({ok_cnt_o, err_cnt_o} !== {16'd12, 16'd0}) begin
      errors++; $display("FAIL ideal_counts: ok %0d err %0d expected 12 0", ok_cnt_o, err_cnt_o);
    end
    checks++;
    if (done_pulses !== 1) begin errors++; $display("FAIL ideal_done_pulses: got %0d expected 1", done_pulses); end
  endtask

  task automatic test_search_err();
    bit to;
    do_start(16'd4, 32'h100);
    // A start while busy must be ignored
    cmd_ready_i = 1'b0; start_i = 1'b1; num_keys_i = 16'd1; key_base_i = 32'h999;
    @(posedge clk); #1;
    start_i = 1'b0;
    run_resp(4, 0, 0, 1, 0, to);
    checks++;
    if (to !== 1'b0 || cmd_log.size() !== 12) begin
      errors++; $display("FAIL err_run: timeout %b hs %0d expected 0 12", to, cmd_log.size());
    end
    checks++;
    if ({ok_cnt_o, err_cnt_o} !== {16'd11, 16'd1}) begin
      errors++; $display("FAIL err_counts: ok %0d err %0d expected 11 1", ok_cnt_o, err_cnt_o);
    end
    checks++;
    if ({first_err_valid_o, first_err_key_o} !== {1'b1, 32'h102}) begin
      errors++; $display("FAIL err_first: valid %b key %h expected 1 00000102", first_err_valid_o, first_err_key_o);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    do_start(16'd8, 32'h2000);
    run_resp(8, 1, 1, 0, 0, to);
    checks++;
    if (to !== 1'b0 || cmd_log.size() !== 24) begin
      errors++; $display("FAIL stall_run: timeout %b hs %0d expected 0 24", to, cmd_log.size());
    end
    checks++;
    if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stall_viol); end
    checks++;
    if (order_viol !== 0) begin errors++; $display("FAIL stall_phase_order: got %0d early searches expected 0", order_viol); end
    checks++;
    if ({ok_cnt_o, err_cnt_o} !== {16'd24, 16'd0}) begin
      errors++; $display("FAIL stall_counts: ok %0d err %0d expected 24 0", ok_cnt_o, err_cnt_o);
    end
  endtask

  task automatic test_n_zero();
    do_start(16'd0, 32'h500);
    checks++;
    if ({done_o, cmd_valid_o, busy_o} !== 3'b100) begin
      errors++; $display("FAIL n0_first: done,valid,busy got %b expected 100", {done_o, cmd_valid_o, busy_o});
    end
    checks++;
    if (ok_cnt_o !== 16'd0) begin errors++; $display("FAIL n0_cleared: ok got %0d expected 0", ok_cnt_o); end
    @(posedge clk); #1;
    checks++;
    if ({done_o, cmd_valid_o, busy_o} !== 3'b000) begin
      errors++; $display("FAIL n0_after: done,valid,busy got %b expected 000", {done_o, cmd_valid_o, busy_o});
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_start(16'd4, 32'h300);
    run_resp(4, 0, 0, 0, 6, to);
    checks++;
    if (cmd_opcode_o !== OP_SEARCH || busy_o !== 1'b1) begin
      errors++; $display("FAIL mid_setup: op %0d busy %b expected 0 1", cmd_opcode_o, busy_o);
    end
    rst_i = 1'b1; res_valid_i = 1'b0; cmd_ready_i = 1'b0;
    #2;
    checks++;
    if ({busy_o, done_o, cmd_valid_o, first_err_valid_o, res_ready_o} !== 5'b00001) begin
      errors++; $display("FAIL mid_reset_flags: got %b expected 00001", {busy_o, done_o, cmd_valid_o, first_err_valid_o, res_ready_o});
    end
    checks++;
    if ({ok_cnt_o, err_cnt_o, cmd_key_o} !== 64'h0) begin
      errors++; $display("FAIL mid_reset_regs: ok %0d err %0d key %h expected 0", ok_cnt_o, err_cnt_o, cmd_key_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    res_valid_i = 1'b1; res_key_i = 32'h302; res_opcode_i = OP_SEARCH;
    res_rescode_i = RC_FOUND; res_found_value_i = 16'h0302 ^ VXOR;
    @(posedge clk); #1;
    res_valid_i = 1'b0;
    checks++;
    if ({ok_cnt_o, err_cnt_o} !== {16'd0, 16'd1}) begin
      errors++; $display("FAIL stray_counts: ok %0d err %0d expected 0 1", ok_cnt_o, err_cnt_o);
    end
    checks++;
    if ({first_err_valid_o, first_err_key_o} !== {1'b1, 32'h302}) begin
      errors++; $display("FAIL stray_first: valid %b key %h expected 1 00000302", first_err_valid_o, first_err_key_o);
    end
  endtask

  task automatic test_wrap();
    bit to;
    do_start(16'd3, 32'hFFFF_FFFE);
    run_resp(3, 0, 0, 0, 0, to);
    checks++;
    if (to !== 1'b0 || cmd_log.size() !== 9) begin
      errors++; $display("FAIL wrap_run: timeout %b hs %0d expected 0 9", to, cmd_log.size());
    end
    if (cmd_log.size() >= 3) begin
      checks++;
      if ({cmd_log[0].key, cmd_log[1].key, cmd_log[2].key} !== {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0}) begin
        errors++; $display("FAIL wrap_keys: got %h %h %h expected fffffffe ffffffff 00000000",
                           cmd_log[0].key, cmd_log[1].key, cmd_log[2].key);
      end
    end
    checks++;
    if ({ok_cnt_o, err_cnt_o} !== {16'd9, 16'd0}) begin
      errors++; $display("FAIL wrap_counts: ok %0d err %0d expected 9 0", ok_cnt_o, err_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_search_err();
    test_back_to_back();
    test_n_zero();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
